sprite_mover: RTL and testbench
===============================

# sprite_mover

Parametrised, tile-aware successor to the free-running ball mover, driving Pac-Man or a ghost. It takes a buffered direction request from the keyboard, checks maze walls through a tile-query handshake, and steps the sprite once per frame tick. Horizontal tunnel wrap-around is included. It sits between the USB keycode path, the maze tile ROM arbiter and the sprite renderer.

## Interface
Parameters:
- TILE_BITS, 3: tile size is 2^TILE_BITS pixels (8).
- MAZE_W, 28: maze width in tiles.
- MAZE_H, 31: maze height in tiles.
- STEP, 1: pixels per move. Must divide 2^TILE_BITS.
- START_X, 104: reset X pixel, top-left of the sprite.
- START_Y, 184: reset Y pixel.
- SIZE, 8: sprite size in pixels, reported on SpriteS.

Ports:
- Clk  in  1: system clock. One clock, all logic on the rising edge.
- Reset  in  1: synchronous, active-high.
- frame_tick  in  1: one-cycle pulse per video frame.
- keycode  in  8: USB HID keycode.
- wall_req  out  1: tile query valid.
- wall_x  out  5: queried tile column.
- wall_y  out  5: queried tile row.
- wall_ack  in  1: query answered. Responds at least 1 cycle after wall_req.
- wall_hit  in  1: queried tile is a wall. Valid only with wall_ack.
- SpriteX  out  10: X pixel.
- SpriteY  out  10: Y pixel.
- SpriteS  out  10: SIZE.
- Dir  out  2: current direction. 00 = right, 01 = left, 10 = up, 11 = down.
- Moving  out  1: sprite advanced or will advance this frame.

## Operation
- Key decode happens every cycle:
  - 0x07 (D) → right; 0x04 (A) → left; 0x1A (W) → up; 0x16 (S) → down.
  - Each decoded key loads req_dir and sets req_valid. A later key overwrites the request.
  - 0x00 and all other codes leave the request unchanged.
- Aligned: the low TILE_BITS bits of both SpriteX and SpriteY are zero.
- Target tile for direction d:
  - (SpriteX>>TILE_BITS)+dx, (SpriteY>>TILE_BITS)+dy.
  - Column wraps modulo MAZE_W: -1 → MAZE_W-1, MAZE_W → 0.
  - Row -1 or MAZE_H is treated as a wall internally and raises no wall_req.
- States: IDLE, TURN_Q, FWD_Q, MOVE.
- IDLE: frame_tick is acted on only in this state. On a tick, take the first matching case:
  1. req_valid, Moving=1, req_dir is the opposite of Dir: Dir←req_dir, clear req_valid, go to MOVE. No query.
  2. Not aligned: go to MOVE.
  3. Aligned, req_valid, req_dir≠Dir: go to TURN_Q targeting req_dir.
  4. Aligned otherwise: clear req_valid if req_dir==Dir, go to FWD_Q targeting Dir.
- TURN_Q:
  - Hold wall_req=1 with wall_x/wall_y stable until wall_ack.
  - On ack with hit=0: Dir←req_dir, clear req_valid, Moving←1, go to MOVE.
  - On ack with hit=1: keep the request, go to FWD_Q.
- FWD_Q: same handshake. On ack, Moving←!wall_hit, go to MOVE.
- MOVE: if Moving, step STEP pixels in Dir. Always return to IDLE.
- Horizontal wrap:
  - Left from X<STEP: X←MAZE_W·2^TILE_BITS−STEP.
  - Right reaching MAZE_W·2^TILE_BITS: X←0.
- No vertical wrap is needed: wall checks stop vertical motion before the edge.
- Width rules: all position math is unsigned 10-bit. Wrap is detected before subtraction, so there is no negative intermediate.

## Timing
- Reset values: SpriteX=START_X, SpriteY=START_Y, Dir=01, Moving=0, req_valid=0, wall_req=0, wall_x=wall_y=0, state IDLE.
- Reset mid-query: wall_req is 0 on the cycle after the Reset edge, and any late wall_ack is ignored.
- No-query path: tick sampled at edge N, state MOVE after N. New position is visible after edge N+1.
- Query path:
  - wall_req rises after edge N.
  - Ack sampled at edge A gives MOVE after A, position updated after A+1.
  - A failed turn adds a second query.
- wall_req drops on the cycle after the ack edge. At most one outstanding query.
- A frame_tick arriving when not in IDLE is dropped: no movement that frame, no queuing.
- Keycode arriving in the same cycle as the IDLE tick: the new request is decoded and latched at that edge and takes effect on the next tick, not the current one.
- SpriteS is constant SIZE.

## Test plan
- Reset then tick, keycode=0: query (12,23); ack hit=0 → Moving=1, Dir=01, SpriteX=103, SpriteY=184.
- From X=103 moving left, key 0x1A: ticks take X to 96 with no queries. At 96, TURN_Q queries (12,22); hit=0 → Dir=10, SpriteY=183.
- Turn blocked: at X=96 with up pending, ack hit=1 → FWD_Q queries (11,23) → X=95. req_valid stays 1 and is retried at X=88.
- Reversal: moving left at X=101, key 0x07 → Dir=00, X=102 one edge after MOVE, no wall_req.
- Tunnel: X=0, Y=112, Dir left: query (27,14) hit=0 → X=223. Then stepping right from X=223 → X=0.
- Reset asserted while wall_req=1 → next cycle all outputs at reset values, wall_req=0. A tick while in FWD_Q with ack delayed 5 cycles → exactly one step for that frame.

Source files
------------

// File: rtl/sprite_mover.sv
// Tile-aware sprite mover: buffers a keyboard direction request, checks maze walls
// over a tile-query handshake and steps the sprite once per frame tick.
module sprite_mover #(
    parameter int TILE_BITS = 3,
    parameter int MAZE_W    = 28,
    parameter int MAZE_H    = 31,
    parameter int STEP      = 1,
    parameter int START_X   = 104,
    parameter int START_Y   = 184,
    parameter int SIZE      = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic       wall_req,
    output logic [4:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [9:0] SpriteX,
    output logic [9:0] SpriteY,
    output logic [9:0] SpriteS,
    output logic [1:0] Dir,
    output logic       Moving
);

    typedef enum logic [1:0] {DIR_RIGHT = 2'b00, DIR_LEFT = 2'b01, DIR_UP = 2'b10, DIR_DOWN = 2'b11} dir_e;
    typedef enum logic [1:0] {IDLE, TURN_Q, FWD_Q, MOVE} state_e;

    localparam logic [9:0] X_SPAN   = 10'(MAZE_W * (1 << TILE_BITS));
    localparam logic [9:0] STEP_V   = 10'(STEP);
    localparam logic [4:0] COL_LAST = 5'(MAZE_W - 1);
    localparam logic [4:0] ROW_LAST = 5'(MAZE_H - 1);

    state_e     state, state_next;
    dir_e       dir, req_dir, new_dir, launch_dir, key_dir;
    logic       req_valid, moving, fake_hit;
    logic [9:0] sprite_x, sprite_y;

    logic       key_hit, aligned, pending, ack_eff, hit_eff;
    logic       launch, drop_req, set_dir, clr_req, set_moving, moving_next, do_step;
    logic [4:0] col, row, tgt_col, tgt_row;
    logic       row_ok;

    assign SpriteX = sprite_x;
    assign SpriteY = sprite_y;
    assign SpriteS = 10'(SIZE);
    assign Dir     = dir;
    assign Moving  = moving;

    assign aligned = (sprite_x[TILE_BITS-1:0] == '0) && (sprite_y[TILE_BITS-1:0] == '0);
    // A query whose target row is off the maze is answered internally as a wall.
    assign pending = wall_req | fake_hit;
    assign ack_eff = fake_hit | (wall_req & wall_ack);
    assign hit_eff = fake_hit | wall_hit;

    always_comb begin
        key_hit = 1'b1;
        key_dir = DIR_RIGHT;
        case (keycode)
            8'h07:   key_dir = DIR_RIGHT;
            8'h04:   key_dir = DIR_LEFT;
            8'h1A:   key_dir = DIR_UP;
            8'h16:   key_dir = DIR_DOWN;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        col     = 5'(sprite_x >> TILE_BITS);
        row     = 5'(sprite_y >> TILE_BITS);
        tgt_col = col;
        tgt_row = row;
        row_ok  = 1'b1;
        case (launch_dir)
            DIR_RIGHT: tgt_col = (col == COL_LAST) ? 5'd0 : col + 5'd1;
            DIR_LEFT:  tgt_col = (col == 5'd0) ? COL_LAST : col - 5'd1;
            DIR_UP:    if (row == 5'd0) row_ok = 1'b0; else tgt_row = row - 5'd1;
            default:   if (row == ROW_LAST) row_ok = 1'b0; else tgt_row = row + 5'd1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        launch_dir  = dir;
        drop_req    = 1'b0;
        set_dir     = 1'b0;
        new_dir     = req_dir;
        clr_req     = 1'b0;
        set_moving  = 1'b0;
        moving_next = moving;
        do_step     = 1'b0;
        case (state)
            IDLE: if (frame_tick) begin
                if (req_valid && moving && (req_dir == dir_e'(dir ^ 2'b01))) begin
                    set_dir    = 1'b1;
                    clr_req    = 1'b1;
                    state_next = MOVE;
                end else if (!aligned) begin
                    state_next = MOVE;
                end else if (req_valid && (req_dir != dir)) begin
                    launch     = 1'b1;
                    launch_dir = req_dir;
                    state_next = TURN_Q;
                end else begin
                    clr_req    = (req_dir == dir);
                    launch     = 1'b1;
                    state_next = FWD_Q;
                end
            end
            TURN_Q: if (ack_eff) begin
                drop_req = 1'b1;
                if (!hit_eff) begin
                    set_dir     = 1'b1;
                    clr_req     = 1'b1;
                    set_moving  = 1'b1;
                    moving_next = 1'b1;
                    state_next  = MOVE;
                end else begin
                    state_next  = FWD_Q;
                end
            end
            FWD_Q: begin
                // After a blocked turn the forward query is issued one cycle later.
                if (!pending) begin
                    launch = 1'b1;
                end else if (ack_eff) begin
                    drop_req    = 1'b1;
                    set_moving  = 1'b1;
                    moving_next = !hit_eff;
                    state_next  = MOVE;
                end
            end
            default: begin
                do_step    = moving;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sprite_x  <= 10'(START_X);
            sprite_y  <= 10'(START_Y);
            dir       <= DIR_LEFT;
            moving    <= 1'b0;
            req_dir   <= DIR_LEFT;
            req_valid <= 1'b0;
            wall_req  <= 1'b0;
            fake_hit  <= 1'b0;
            wall_x    <= '0;
            wall_y    <= '0;
        end else begin
            if (launch) begin
                wall_x   <= tgt_col;
                wall_y   <= tgt_row;
                wall_req <= row_ok;
                fake_hit <= !row_ok;
            end else if (drop_req) begin
                wall_req <= 1'b0;
                fake_hit <= 1'b0;
            end
            if (set_dir)    dir    <= new_dir;
            if (set_moving) moving <= moving_next;
            // A key landing on the same edge as a clear wins; it applies next tick.
            if (key_hit) begin
                req_dir   <= key_dir;
                req_valid <= 1'b1;
            end else if (clr_req) begin
                req_valid <= 1'b0;
            end
            if (do_step) begin
                case (dir)
                    DIR_RIGHT: sprite_x <= (sprite_x + STEP_V >= X_SPAN) ? 10'd0 : sprite_x + STEP_V;
                    DIR_LEFT:  sprite_x <= (sprite_x < STEP_V) ? X_SPAN - STEP_V : sprite_x - STEP_V;
                    DIR_UP:    sprite_y <= sprite_y - STEP_V;
                    default:   sprite_y <= sprite_y + STEP_V;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed testbench for sprite_mover: start-up query, turns, blocked turn,
// reversal, tunnel wrap, reset mid-query and ticks dropped during a query.
module tb_sprite_mover;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       tick_a, tick_b;
    logic       wall_req_a, wall_ack_a, wall_hit_a;
    logic [4:0] wall_x_a, wall_y_a;
    logic [9:0] x_a, y_a, s_a;
    logic [1:0] dir_a;
    logic       mov_a;
    logic       wall_req_b, wall_ack_b, wall_hit_b;
    logic [4:0] wall_x_b, wall_y_b;
    logic [9:0] x_b, y_b, s_b;
    logic [1:0] dir_b;
    logic       mov_b;

    int n_checks = 0;
    int n_errors = 0;
    logic q_seen;

    always #5 Clk = ~Clk;

    sprite_mover u_dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick_a), .keycode(keycode),
        .wall_req(wall_req_a), .wall_x(wall_x_a), .wall_y(wall_y_a),
        .wall_ack(wall_ack_a), .wall_hit(wall_hit_a),
        .SpriteX(x_a), .SpriteY(y_a), .SpriteS(s_a), .Dir(dir_a), .Moving(mov_a)
    );

    // Second instance starts in the tunnel row at the left edge.
    sprite_mover #(.START_X(0), .START_Y(112)) u_tun (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick_b), .keycode(keycode),
        .wall_req(wall_req_b), .wall_x(wall_x_b), .wall_y(wall_y_b),
        .wall_ack(wall_ack_b), .wall_hit(wall_hit_b),
        .SpriteX(x_b), .SpriteY(y_b), .SpriteS(s_b), .Dir(dir_b), .Moving(mov_b)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic pulse_tick_a();
        @(negedge Clk);
        tick_a = 1'b1;
        @(negedge Clk);
        tick_a = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge Clk);
        keycode = k;
        @(negedge Clk);
        keycode = 8'h00;
    endtask

    task automatic settle();
        repeat (2) @(negedge Clk);
    endtask

    task automatic wait_req_a(input string tag, input logic [4:0] ex, input logic [4:0] ey);
        int n = 0;
        while (!wall_req_a && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_req"}, wall_req_a, 1);
        check({tag, "_wx"}, wall_x_a, ex);
        check({tag, "_wy"}, wall_y_a, ey);
    endtask

    task automatic ack_a(input logic hit, input int delay);
        repeat (delay) @(negedge Clk);
        wall_ack_a = 1'b1;
        wall_hit_a = hit;
        @(negedge Clk);
        wall_ack_a = 1'b0;
        wall_hit_a = 1'b0;
    endtask

    // Tick with no query expected; any wall_req seen is accumulated in q_seen.
    task automatic tick_noq_a();
        pulse_tick_a();
        q_seen = q_seen | wall_req_a;
        repeat (2) begin
            @(negedge Clk);
            q_seen = q_seen | wall_req_a;
        end
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; tick_a = 1'b0; tick_b = 1'b0;
        wall_ack_a = 1'b0; wall_hit_a = 1'b0; wall_ack_b = 1'b0; wall_hit_b = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        check("rst_x", x_a, 104);
        check("rst_y", y_a, 184);
        check("rst_dir", dir_a, 2'b01);
        check("rst_mov", mov_a, 0);
        check("rst_req", wall_req_a, 0);
        check("rst_wx", wall_x_a, 0);
        check("size", s_a, 8);

        // Start-up: forward query to the left, open.
        pulse_tick_a();
        wait_req_a("start", 5'd12, 5'd23);
        ack_a(1'b0, 1);
        settle();
        check("start_req_drop", wall_req_a, 0);
        check("start_mov", mov_a, 1);
        check("start_dir", dir_a, 2'b01);
        check("start_x", x_a, 103);
        check("start_y", y_a, 184);

        // Up request buffered; no queries until aligned at 96.
        press(8'h1A);
        q_seen = 1'b0;
        repeat (7) tick_noq_a();
        check("to96_noq", q_seen, 0);
        check("to96_x", x_a, 96);

        // Turn up blocked, then forward query continues left.
        pulse_tick_a();
        wait_req_a("turn96", 5'd12, 5'd22);
        ack_a(1'b1, 1);
        wait_req_a("fwd96", 5'd11, 5'd23);
        ack_a(1'b0, 2);
        settle();
        check("blk_x", x_a, 95);
        check("blk_dir", dir_a, 2'b01);

        q_seen = 1'b0;
        repeat (7) tick_noq_a();
        check("to88_noq", q_seen, 0);
        check("to88_x", x_a, 88);

        // Retried turn at 88 succeeds.
        pulse_tick_a();
        wait_req_a("turn88", 5'd11, 5'd22);
        ack_a(1'b0, 1);
        settle();
        check("turn_dir", dir_a, 2'b10);
        check("turn_x", x_a, 88);
        check("turn_y", y_a, 183);

        // Reversal without a query.
        do_reset();
        pulse_tick_a();
        wait_req_a("rev_start", 5'd12, 5'd23);
        ack_a(1'b0, 1);
        settle();
        tick_noq_a();
        tick_noq_a();
        check("rev_x0", x_a, 101);
        press(8'h07);
        q_seen = 1'b0;
        pulse_tick_a();
        q_seen = q_seen | wall_req_a;
        check("rev_pre_x", x_a, 101);
        @(negedge Clk);
        q_seen = q_seen | wall_req_a;
        check("rev_x", x_a, 102);
        check("rev_dir", dir_a, 2'b00);
        check("rev_noq", q_seen, 0);

        // Tunnel on the second instance.
        do_reset();
        check("tun_rst_x", x_b, 0);
        @(negedge Clk);
        tick_b = 1'b1;
        @(negedge Clk);
        tick_b = 1'b0;
        begin
            int n = 0;
            while (!wall_req_b && n < 20) begin
                @(negedge Clk);
                n++;
            end
        end
        check("tun_req", wall_req_b, 1);
        check("tun_wx", wall_x_b, 27);
        check("tun_wy", wall_y_b, 14);
        @(negedge Clk);
        wall_ack_b = 1'b1;
        @(negedge Clk);
        wall_ack_b = 1'b0;
        settle();
        check("tun_x_left", x_b, 223);
        check("tun_mov", mov_b, 1);
        press(8'h07);
        @(negedge Clk);
        tick_b = 1'b1;
        @(negedge Clk);
        tick_b = 1'b0;
        check("tun_noq", wall_req_b, 0);
        settle();
        check("tun_x_right", x_b, 0);
        check("tun_dir", dir_b, 2'b00);

        // Reset while a query is outstanding; a late ack is ignored.
        do_reset();
        pulse_tick_a();
        wait_req_a("rq", 5'd12, 5'd23);
        Reset = 1'b1;
        @(negedge Clk);
        check("rq_req", wall_req_a, 0);
        check("rq_x", x_a, 104);
        check("rq_y", y_a, 184);
        check("rq_dir", dir_a, 2'b01);
        check("rq_mov", mov_a, 0);
        check("rq_wx", wall_x_a, 0);
        check("rq_wy", wall_y_a, 0);
        Reset = 1'b0;
        ack_a(1'b0, 1);
        repeat (3) @(negedge Clk);
        check("late_ack_mov", mov_a, 0);
        check("late_ack_x", x_a, 104);
        check("late_ack_req", wall_req_a, 0);

        // Tick during a slow query is dropped: one step for the frame.
        pulse_tick_a();
        wait_req_a("slow", 5'd12, 5'd23);
        repeat (2) @(negedge Clk);
        pulse_tick_a();
        repeat (2) @(negedge Clk);
        check("slow_hold_req", wall_req_a, 1);
        ack_a(1'b0, 0);
        settle();
        check("slow_x", x_a, 103);
        repeat (6) @(negedge Clk);
        check("slow_x_hold", x_a, 103);
        check("slow_req_idle", wall_req_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
